sms_timing_ring: RTL

Timing-pulse source for the SMS trigger cards. It generates the one-tick AC-set pulses and the DC gate levels that the binary-trigger cards consume on their AC-set and gate pins. It models a free-running or single-shot timing ring with NUM_POS positions (A, B, C, ...), each held for DWELL ticks of `x`. Its outputs wire directly to trigger-card AC-set and gate inputs in the 1620 logic reproduction.

---
 rtl/sms_timing_pkg.sv | 26 ++
 rtl/sms_dwell_counter.sv | 29 ++
 rtl/sms_timing_ring.sv | 95 +++++++++
 3 files changed

// File: rtl/sms_timing_pkg.sv
// Shared types and constants for the SMS timing ring: ring state encoding,
// default geometry and named ring positions A..J.
package sms_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALT_PEND = 2'd2
  } ring_state_e;

  localparam int DEF_NUM_POS = 10;
  localparam int DEF_DWELL   = 4;
  localparam int DEF_CNT_W   = 8;

  localparam int POS_A = 0;
  localparam int POS_B = 1;
  localparam int POS_C = 2;
  localparam int POS_D = 3;
  localparam int POS_E = 4;
  localparam int POS_F = 5;
  localparam int POS_G = 6;
  localparam int POS_H = 7;
  localparam int POS_I = 8;
  localparam int POS_J = 9;

endpackage

// File: rtl/sms_dwell_counter.sv
// Modulo-DWELL tick counter for one ring position. Flags the first and the
// terminal tick of the dwell; parks at zero whenever it is not enabled.
module sms_dwell_counter
  import sms_timing_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic x,
  input  logic rst_n,
  input  logic en,
  output logic tc,
  output logic first
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

  logic [DW-1:0] dwell;

  // Wrapping at tc leaves the counter at zero when the ring drops to idle.
  always_ff @(posedge x or negedge rst_n) begin
    if (!rst_n)  dwell <= '0;
    else if (en) dwell <= tc ? '0 : dwell + 1'b1;
  end

  assign tc    = (dwell == LAST);
  assign first = (dwell == '0);

endmodule

// File: rtl/sms_timing_ring.sv
// Timing ring for the SMS trigger cards: steps a one-hot gate level through
// NUM_POS positions, each held DWELL ticks, with an AC-set pulse per position.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ring stopped, all outputs low, waiting for start_n
// RUN       | ring cycling; wraps to A at end of cycle unless single-shot
// HALT_PEND | stop seen; finish the current cycle, then go IDLE
module sms_timing_ring
  import sms_timing_pkg::*;
#(
  parameter int NUM_POS = DEF_NUM_POS,
  parameter int DWELL   = DEF_DWELL,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               x,
  input  logic               rst_n,
  input  logic               start_n,
  input  logic               stop_n,
  input  logic               single_n,
  output logic [NUM_POS-1:0] level,
  output logic [NUM_POS-1:0] ac_pulse,
  output logic               cycle_end,
  output logic               running,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int PW = $clog2(NUM_POS);
  localparam logic [PW-1:0] FIRST_POS = PW'(POS_A);
  localparam logic [PW-1:0] LAST_POS  = PW'(NUM_POS - 1);

  ring_state_e       state, state_nxt;
  logic [PW-1:0]     pos, pos_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              active;
  logic              dwell_tc;
  logic              dwell_first;
  logic              end_tick;

  assign active   = (state != IDLE);
  assign end_tick = active && dwell_tc && (pos == LAST_POS);

  sms_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .x     (x),
    .rst_n (rst_n),
    .en    (active),
    .tc    (dwell_tc),
    .first (dwell_first)
  );

  always_ff @(posedge x or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos   <= FIRST_POS;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  // A stop on the end tick itself is honoured immediately, so stop never
  // buys an extra cycle.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    unique case (state)
      IDLE:      if (!start_n && stop_n) state_nxt = RUN;
      RUN: begin
        if (end_tick && (!single_n || !stop_n)) state_nxt = IDLE;
        else if (!end_tick && !stop_n)          state_nxt = HALT_PEND;
      end
      HALT_PEND: if (end_tick) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (active && dwell_tc) pos_nxt = end_tick ? FIRST_POS : pos + 1'b1;
  end

  always_ff @(posedge x or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (end_tick) cnt <= cnt + 1'b1;
  end

  // Outputs decode straight from the registers so a start edge shows
  // position A with no added latency and reset clears them immediately.
  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_POS; i++) level[i] = active && (pos == PW'(i));
  end

  assign ac_pulse    = dwell_first ? level : '0;
  assign cycle_end   = end_tick;
  assign running     = active;
  assign cycle_count = cnt;

endmodule
